// File: rtl/keypad_pkg.sv
// Shared types and constants for the 3x4 telephone keypad scanner.
package keypad_pkg;

    localparam int SCAN_DIV_DEF   = 4;
    localparam int DEB_FRAMES_DEF = 3;
    localparam int NUM_ROWS       = 4;
    localparam int NUM_COLS       = 3;
    localparam int NUM_KEYS       = NUM_ROWS * NUM_COLS;

    localparam logic [3:0] NO_DIGIT = 4'hF;

    // Nibble i is the digit at row i/3, column i%3; '*' and '#' map to NO_DIGIT.
    localparam logic [4*NUM_KEYS-1:0] KEY_MAP = {
        4'hF, 4'h0, 4'hF,
        4'h9, 4'h8, 4'h7,
        4'h6, 4'h5, 4'h4,
        4'h3, 4'h2, 4'h1
    };

    typedef enum logic [1:0] {
        IDLE,
        DEBOUNCE,
        PRESSED,
        RELEASE
    } kp_state_e;

    function automatic logic [9:0] map_frame(input logic [NUM_KEYS-1:0] keys);
        logic [9:0] f;
        logic [3:0] d;
        f = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            d = KEY_MAP[4*i +: 4];
            for (int j = 0; j < 10; j++) begin
                if (keys[i] && d == 4'(j)) f[j] = 1'b1;
            end
        end
        return f;
    endfunction

    function automatic logic [3:0] encode(input logic [9:0] oh);
        logic [3:0] code;
        code = '0;
        for (int j = 0; j < 10; j++) begin
            if (oh[j]) code = 4'(j);
        end
        return code;
    endfunction

endpackage

// File: rtl/keypad_col_scan.sv
// Column strobe generator and row sampler; emits one 12-key snapshot per frame.
module keypad_col_scan
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV = SCAN_DIV_DEF
) (
    input  logic                clk,
    input  logic                clear_n,
    input  logic [NUM_ROWS-1:0] rows_n,
    output logic [NUM_COLS-1:0] cols_n,
    output logic [NUM_KEYS-1:0] frame,
    output logic                frame_done
);

    localparam int SW = $clog2(SCAN_DIV);
    localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);

    logic [NUM_ROWS-1:0] sync1;
    logic [NUM_ROWS-1:0] sync2;
    logic                started;
    logic [1:0]          idx;
    logic [SW-1:0]       slot;
    logic [NUM_KEYS-1:0] acc;
    logic [NUM_KEYS-1:0] acc_next;
    logic                slot_end;

    assign slot_end = started && (slot == SLOT_LAST);
    assign cols_n   = started ? ~(3'b001 << idx) : 3'b111;

    // Merge the current column's rows into the frame being built.
    always_comb begin
        acc_next = acc;
        for (int r = 0; r < NUM_ROWS; r++) begin
            acc_next[NUM_COLS*r + int'(idx)] = ~sync2[r];
        end
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            sync1      <= '0;
            sync2      <= '0;
            started    <= 1'b0;
            idx        <= '0;
            slot       <= '0;
            acc        <= '0;
            frame      <= '0;
            frame_done <= 1'b0;
        end else begin
            sync1      <= rows_n;
            sync2      <= sync1;
            started    <= 1'b1;
            frame_done <= 1'b0;
            if (slot_end) begin
                slot <= '0;
                acc  <= acc_next;
                if (idx == 2'd2) begin
                    idx        <= '0;
                    frame      <= acc_next;
                    frame_done <= 1'b1;
                end else begin
                    idx <= idx + 2'd1;
                end
            end else if (started) begin
                slot <= slot + SW'(1);
            end
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// Keypad scanner top: per-frame press/release debounce FSM over the column scanner.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV   = SCAN_DIV_DEF,
    parameter int DEB_FRAMES = DEB_FRAMES_DEF
) (
    input  logic                clk,
    input  logic                clear_n,
    input  logic [NUM_ROWS-1:0] rows_n,
    output logic [NUM_COLS-1:0] cols_n,
    output logic [9:0]          keypad,
    output logic                key_valid,
    output logic [3:0]          key_code
);

    localparam int CW = $clog2(DEB_FRAMES + 2);
    localparam logic [CW-1:0] DEB_CNT = CW'(DEB_FRAMES);

    logic [NUM_KEYS-1:0] frame;
    logic                frame_done;

    keypad_col_scan #(
        .SCAN_DIV (SCAN_DIV)
    ) u_col_scan (
        .clk        (clk),
        .clear_n    (clear_n),
        .rows_n     (rows_n),
        .cols_n     (cols_n),
        .frame      (frame),
        .frame_done (frame_done)
    );

    kp_state_e     state, state_n;
    logic [9:0]    cand, cand_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [CW-1:0] rcnt, rcnt_n;
    logic [9:0]    keypad_n;
    logic [3:0]    code_n;
    logic          valid_n;
    logic [9:0]    f;
    logic          single;
    logic          empty;

    assign f      = map_frame(frame);
    assign single = $onehot(f);
    assign empty  = (frame == '0);

    always_comb begin
        state_n  = state;
        cand_n   = cand;
        cnt_n    = cnt;
        rcnt_n   = rcnt;
        keypad_n = keypad;
        code_n   = key_code;
        valid_n  = 1'b0;
        if (frame_done) begin
            unique case (state)
                IDLE: begin
                    if (single) begin
                        cand_n = f;
                        cnt_n  = CW'(1);
                        if (DEB_FRAMES == 1) begin
                            state_n  = PRESSED;
                            keypad_n = f;
                            code_n   = encode(f);
                            valid_n  = 1'b1;
                        end else begin
                            state_n = DEBOUNCE;
                        end
                    end
                end
                DEBOUNCE: begin
                    if (single && f == cand) begin
                        cnt_n = cnt + CW'(1);
                        if (cnt_n >= DEB_CNT) begin
                            state_n  = PRESSED;
                            keypad_n = cand;
                            code_n   = encode(cand);
                            valid_n  = 1'b1;
                        end
                    end else if (single) begin
                        cand_n = f;
                        cnt_n  = CW'(1);
                    end else begin
                        state_n = IDLE;
                    end
                end
                PRESSED: begin
                    if (empty) begin
                        state_n = RELEASE;
                        rcnt_n  = CW'(1);
                    end
                end
                RELEASE: begin
                    if (empty) begin
                        rcnt_n = rcnt + CW'(1);
                        if (rcnt_n >= DEB_CNT) begin
                            state_n  = IDLE;
                            keypad_n = '0;
                        end
                    end else begin
                        state_n = PRESSED;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state     <= IDLE;
            cand      <= '0;
            cnt       <= '0;
            rcnt      <= '0;
            keypad    <= '0;
            key_code  <= '0;
            key_valid <= 1'b0;
        end else begin
            state     <= state_n;
            cand      <= cand_n;
            cnt       <= cnt_n;
            rcnt      <= rcnt_n;
            keypad    <= keypad_n;
            key_code  <= code_n;
            key_valid <= valid_n;
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural 3x4 key matrix.
module tb_keypad_scanner;

    localparam int FRAME = 12;
    localparam int LAT   = 4 * FRAME + 3;

    logic       clk;
    logic       clear_n;
    logic [3:0] rows_n;
    logic [2:0] cols_n;
    logic [9:0] keypad;
    logic       key_valid;
    logic [3:0] key_code;
    logic [11:0] keys;

    int vectors;
    int miscompares;
    int exp_q[$];

    keypad_scanner dut (
        .clk       (clk),
        .clear_n   (clear_n),
        .rows_n    (rows_n),
        .cols_n    (cols_n),
        .keypad    (keypad),
        .key_valid (key_valid),
        .key_code  (key_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Closed switch pulls its row low when its column is strobed.
    always_comb begin
        rows_n = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 3; c++) begin
                if (keys[3*r + c] && !cols_n[c]) rows_n[r] = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_frames(input int n);
        repeat (n * FRAME) @(negedge clk);
    endtask

    task automatic wait_valid(input string tag, input int budget);
        logic got;
        got = 1'b0;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (key_valid) begin
                got = 1'b1;
                break;
            end
        end
        check(tag, 32'(got), 32'd1);
    endtask

    // Every key_valid pulse must match the oldest expected press.
    always @(negedge clk) begin
        if (key_valid) begin
            if (exp_q.size() == 0) begin
                check("spurious_valid", 32'(key_valid), 32'd0);
            end else begin
                int e;
                e = exp_q.pop_front();
                check("pulse_code", 32'(key_code), 32'(e));
                check("pulse_keypad", 32'(keypad), 32'd1 << e);
            end
        end
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        keys        = '0;
        clear_n     = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_cols", 32'(cols_n), 32'b111);
        check("rst_keypad", 32'(keypad), 32'd0);
        check("rst_valid", 32'(key_valid), 32'd0);
        check("rst_code", 32'(key_code), 32'd0);

        clear_n = 1'b1;
        @(posedge clk);
        #1 check("scan_c0", 32'(cols_n), 32'b110);
        repeat (4) @(posedge clk);
        #1 check("scan_c1", 32'(cols_n), 32'b101);
        repeat (4) @(posedge clk);
        #1 check("scan_c2", 32'(cols_n), 32'b011);
        repeat (4) @(posedge clk);
        #1 check("scan_wrap", 32'(cols_n), 32'b110);

        // '5' held for 6 frames
        @(negedge clk);
        exp_q.push_back(5);
        keys = 12'b0000_0001_0000;
        wait_valid("lat_5", LAT);
        wait_frames(2);
        check("hold5_keypad", 32'(keypad), 32'b0000100000);
        check("hold5_code", 32'(key_code), 32'd5);
        keys = '0;
        wait_frames(5);
        check("rel5_keypad", 32'(keypad), 32'd0);
        check("rel5_code_kept", 32'(key_code), 32'd5);

        // '7' bouncing once per frame
        for (int i = 0; i < 8; i++) begin
            keys = (i % 2 == 0) ? 12'b0000_0100_0000 : 12'b0;
            wait_frames(1);
            check("bounce_keypad", 32'(keypad), 32'd0);
        end
        keys = '0;
        wait_frames(3);

        // '1'+'2' together, then '*' alone
        keys = 12'b0000_0000_0011;
        wait_frames(5);
        check("multi_keypad", 32'(keypad), 32'd0);
        keys = 12'b0010_0000_0000;
        wait_frames(5);
        check("star_keypad", 32'(keypad), 32'd0);
        keys = '0;
        wait_frames(3);

        // short release must not end the press
        exp_q.push_back(5);
        keys = 12'b0000_0001_0000;
        wait_valid("lat_5b", LAT);
        wait_frames(2);
        keys = '0;
        wait_frames(2);
        check("short_rel_keypad", 32'(keypad), 32'b0000100000);
        keys = 12'b0000_0001_0000;
        wait_frames(3);
        check("repress_keypad", 32'(keypad), 32'b0000100000);
        keys = '0;
        wait_frames(5);
        check("full_rel_keypad", 32'(keypad), 32'd0);

        exp_q.push_back(9);
        keys = 12'b0001_0000_0000;
        wait_valid("lat_9", LAT);
        check("hold9_code", 32'(key_code), 32'd9);
        keys = '0;
        wait_frames(5);
        check("rel9_keypad", 32'(keypad), 32'd0);

        // reset while '3' is held
        exp_q.push_back(3);
        keys = 12'b0000_0000_0100;
        wait_valid("lat_3", LAT);
        wait_frames(1);
        #2 clear_n = 1'b0;
        #1;
        check("async_keypad", 32'(keypad), 32'd0);
        check("async_cols", 32'(cols_n), 32'b111);
        check("async_code", 32'(key_code), 32'd0);
        repeat (3) @(negedge clk);
        exp_q.push_back(3);
        clear_n = 1'b1;
        wait_valid("lat_3_after_rst", LAT);
        check("post_rst_keypad", 32'(keypad), 32'b0000001000);
        keys = '0;
        wait_frames(5);
        check("post_rst_rel", 32'(keypad), 32'd0);

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 The block SHALL have parameter SCAN_DIV, default 4: clocks per column slot (>=2).
REQ-002 The block SHALL have parameter DEB_FRAMES, default 3: consecutive identical frames needed to accept a press or a release (>=1).
REQ-003 The block SHALL have port clk, input, 1: the single clock; all state advances on its rising edge.
REQ-004 The block SHALL have port clear_n, input, 1: reset, asynchronous and active-low.
REQ-005 The block SHALL have port rows_n, input, 4: matrix row lines, active-low, externally pulled up, asynchronous to clk.
REQ-006 The block SHALL have port cols_n, output, 3: matrix column strobes, active-low, at most one low at any time.
REQ-007 The block SHALL have port keypad, output, 10: one-hot debounced digit (bit d set means digit d is held), or zero.
REQ-008 The block SHALL have port key_valid, output, 1: one-clock pulse when a new press is accepted.
REQ-009 The block SHALL have port key_code, output, 4: binary digit 0-9 of the last accepted press.

Function
REQ-010 Key map (row,col) SHALL be: r0: 1,2,3; r1: 4,5,6; r2: 7,8,9; r3: *,0,#. The * and # keys SHALL never produce a digit.
REQ-011 rows_n SHALL pass through a 2-flop synchronizer before any use.
REQ-012 Column index SHALL cycle 0,1,2,0 with SCAN_DIV clocks per slot; cols_n = ~(1<<index).
REQ-013 Synchronized rows SHALL be sampled on the last clock of each slot; 3 slots form one frame of 3*SCAN_DIV clocks.
REQ-014 At frame end, the 12 samples SHALL be mapped to a 10-bit digit vector F; a frame is "single" if popcount(F)==1, "empty" if all 12 keys are released, otherwise "other".
REQ-015 FSM states SHALL be IDLE, DEBOUNCE, PRESSED, RELEASE, evaluated only at frame end.
REQ-016 In IDLE, a single frame SHALL load cand=F and cnt=1, then go to DEBOUNCE (direct to PRESSED if DEB_FRAMES==1); any other frame SHALL stay in IDLE.
REQ-017 In DEBOUNCE, F==cand SHALL increment cnt, and on cnt reaching DEB_FRAMES SHALL go to PRESSED. A different single frame SHALL reload cand with cnt=1. An empty or other frame SHALL go to IDLE.
REQ-018 On entry to PRESSED, the block SHALL set keypad=cand and key_code=encode(cand), and SHALL raise key_valid for exactly one clock.
REQ-019 In PRESSED, an empty frame SHALL go to RELEASE with rcnt=1; any non-empty frame, including multi-key frames, SHALL hold the key with no repeat pulse.
REQ-020 In RELEASE, an empty frame SHALL increment rcnt, and on rcnt reaching DEB_FRAMES SHALL clear keypad to 0 and go to IDLE. A non-empty frame SHALL return to PRESSED with no pulse.
REQ-021 key_code SHALL hold its value until the next accepted press.
REQ-022 Latency SHALL be at most DEB_FRAMES+1 frames plus 3 clocks from stable press to key_valid.

Reset
REQ-023 When clear_n is low, the block SHALL immediately force cols_n=3'b111, keypad=0, key_valid=0, key_code=0, state=IDLE, and index, slot counter, cnt, rcnt and synchronizer flops all to 0.
REQ-024 After clear_n deasserts, the block SHALL drive cols_n=3'b110 on the first clock, and a full new frame SHALL be required before any decision.
REQ-025 Reset mid-press SHALL drop keypad without a release sequence.

Structure
REQ-026 Package keypad_pkg SHALL hold the state enum, the key-map constant, and the SCAN_DIV/DEB_FRAMES defaults.
REQ-027 Sub-module keypad_col_scan SHALL contain the synchronizer, column drive and sampling, and SHALL output the 12-bit frame snapshot plus a frame_done pulse; the top level SHALL contain the FSM.

Verification
REQ-028 Reset: hold clear_n low -> cols_n=111 and keypad=0. Release -> cols_n=110, then 101 and 011 at 4-clock spacing.
REQ-029 Press '5' (r1,c1) for 6 frames -> exactly one key_valid, key_code=5, keypad=10'b0000100000 within 4 frames.
REQ-030 Bounce: toggle '7' on/off every frame for 8 frames -> key_valid never asserts and keypad stays 0.
REQ-031 Press '1' and '2' together, then '*' alone, each for 5 frames -> no key_valid.
REQ-032 Press '5', release for 2 frames, press again -> no new pulse. Full 3-frame release -> keypad=0. Press '9' -> key_valid, key_code=9.
REQ-033 Assert clear_n low while '3' is PRESSED -> keypad=0 asynchronously. Release clear_n with '3' still held -> a new key_valid with code 3 after debounce.
